// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and the byte type used by RX, TX and
//                the transmit FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int CLOCK_FREQ      = 50_000_000;
  localparam int BAUD_RATE       = 115_200;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : First-word-fall-through byte FIFO feeding the UART
//                transmitter, with sticky overflow and occupancy reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH        = UART_DATA_WIDTH,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                     sample_clock,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     almost_full,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] c_one      = PW'(1);
  localparam logic [PW-1:0] c_af_level = PW'(ALMOST_FULL_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_level;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_push  = wr_en && !w_full;
  assign w_pop   = !w_empty && tx_ready;

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      // A rejected push takes priority over a simultaneous clear.
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset; only the pointers define content.
  always_ff @(posedge sample_clock) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign full        = w_full;
  assign almost_full = (w_level >= c_af_level);
  assign level       = w_level;
  assign tx_valid    = !w_empty;
  assign tx_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign overflow    = r_overflow;

endmodule : uart_tx_fifo

`default_nettype wire
